// File: rtl/pipe_ctrl_regs_pkg.sv
// Shared pipeline widths and the stall-watchdog state encoding.
package pipe_ctrl_regs_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ALUC_W = 3;

    localparam logic [7:0] RUN_MAX = 8'hFF;

    typedef enum logic {
        IDLE     = 1'b0,
        STALLING = 1'b1
    } wdState_t;

endpackage

// File: rtl/pipe_ctrl_regs_if.sv
// F/D and D/E pipeline datapath bundle; master drives the fetch/decode side.
interface pipe_ctrl_regs_if;
    import pipe_ctrl_regs_pkg::*;

    logic [DATA_W-1:0] pcF, instrF;
    logic              predict_takenF;
    logic [DATA_W-1:0] pcD, instrD;
    logic              predict_takenD, validD;

    logic [REG_W-1:0]  rsD, rtD, writeregD;
    logic              regwriteD, memtoregD, memwriteD, alusrcD;
    logic [ALUC_W-1:0] alucontrolD;
    logic [DATA_W-1:0] srcaD, srcbD, signimmD;

    logic [REG_W-1:0]  rsE, rtE, writeregE;
    logic              regwriteE, memtoregE, memwriteE, alusrcE, validE;
    logic [ALUC_W-1:0] alucontrolE;
    logic [DATA_W-1:0] srcaE, srcbE, signimmE, pcE;

    modport master (
        output pcF, instrF, predict_takenF,
        output rsD, rtD, writeregD, regwriteD, memtoregD, memwriteD, alusrcD,
        output alucontrolD, srcaD, srcbD, signimmD,
        input  pcD, instrD, predict_takenD, validD,
        input  rsE, rtE, writeregE, regwriteE, memtoregE, memwriteE, alusrcE, validE,
        input  alucontrolE, srcaE, srcbE, signimmE, pcE
    );

    modport slave (
        input  pcF, instrF, predict_takenF,
        input  rsD, rtD, writeregD, regwriteD, memtoregD, memwriteD, alusrcD,
        input  alucontrolD, srcaD, srcbD, signimmD,
        output pcD, instrD, predict_takenD, validD,
        output rsE, rtE, writeregE, regwriteE, memtoregE, memwriteE, alusrcE, validE,
        output alucontrolE, srcaE, srcbE, signimmE, pcE
    );

endinterface

// File: rtl/pipe_ctrl_regs_watchdog.sv
// Decode-stall watchdog: counts consecutive stallD cycles and latches a sticky timeout.
module pipe_watchdog
    import pipe_ctrl_regs_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stallD,
    output logic stall_timeout
);

    wdState_t   state, nextState;
    logic [7:0] run, nextRun;

    always_comb begin
        nextState = state;
        nextRun   = run;
        if (!stallD) begin
            nextState = IDLE;
            nextRun   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nextState = STALLING;
                    nextRun   = 8'd1;
                end
                STALLING: begin
                    nextRun = (run == RUN_MAX) ? run : run + 8'd1;
                end
                default: begin
                    nextState = IDLE;
                    nextRun   = '0;
                end
            endcase
        end
    end

    // Timeout latches one cycle after run reaches the limit, even if the stall ends then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            run           <= '0;
            stall_timeout <= 1'b0;
        end else begin
            state <= nextState;
            run   <= nextRun;
            if (32'(run) == STALL_LIMIT)
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// F/D and D/E pipeline registers with stall/flush performance counters and watchdog.
module pipe_ctrl_regs
    import pipe_ctrl_regs_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stallF,
    input  logic                   stallD,
    input  logic                   flushD,
    input  logic                   flushE,
    pipe_ctrl_regs_if.slave        pipe,
    output logic [DATA_W-1:0]      stall_cnt,
    output logic [DATA_W-1:0]      flush_cnt,
    output logic                   stall_timeout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe.pcD            <= '0;
            pipe.instrD         <= '0;
            pipe.predict_takenD <= 1'b0;
            pipe.validD         <= 1'b0;
        end else if (flushD) begin
            pipe.pcD            <= '0;
            pipe.instrD         <= '0;
            pipe.predict_takenD <= 1'b0;
            pipe.validD         <= 1'b0;
        end else if (!stallD) begin
            pipe.pcD            <= pipe.pcF;
            pipe.instrD         <= pipe.instrF;
            pipe.predict_takenD <= pipe.predict_takenF;
            pipe.validD         <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flushE) begin
            if (!rst_n || flushE) begin
                pipe.rsE         <= '0;
                pipe.rtE         <= '0;
                pipe.writeregE   <= '0;
                pipe.regwriteE   <= 1'b0;
                pipe.memtoregE   <= 1'b0;
                pipe.memwriteE   <= 1'b0;
                pipe.alusrcE     <= 1'b0;
                pipe.validE      <= 1'b0;
                pipe.alucontrolE <= '0;
                pipe.srcaE       <= '0;
                pipe.srcbE       <= '0;
                pipe.signimmE    <= '0;
                pipe.pcE         <= '0;
            end
        end else begin
            pipe.rsE         <= pipe.rsD;
            pipe.rtE         <= pipe.rtD;
            pipe.writeregE   <= pipe.writeregD;
            pipe.regwriteE   <= pipe.regwriteD;
            pipe.memtoregE   <= pipe.memtoregD;
            pipe.memwriteE   <= pipe.memwriteD;
            pipe.alusrcE     <= pipe.alusrcD;
            pipe.validE      <= pipe.validD;
            pipe.alucontrolE <= pipe.alucontrolD;
            pipe.srcaE       <= pipe.srcaD;
            pipe.srcbE       <= pipe.srcbD;
            pipe.signimmE    <= pipe.signimmD;
            pipe.pcE         <= pipe.pcD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((stallF || stallD) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if ((flushD || flushE) && flush_cnt != '1)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    pipe_watchdog #(
        .STALL_LIMIT(STALL_LIMIT)
    ) uWatchdog (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallD       (stallD),
        .stall_timeout(stall_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed bench for pipe_ctrl_regs: load, stall/flush interplay, watchdog, saturation, async reset.
module tb_pipe_ctrl_regs;
    import pipe_ctrl_regs_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, flushE = 1'b0;
    logic [31:0] stall_cnt, flush_cnt;
    logic stall_timeout;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pipe_ctrl_regs_if pipe ();

    pipe_ctrl_regs #(
        .STALL_LIMIT(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallF       (stallF),
        .stallD       (stallD),
        .flushD       (flushD),
        .flushE       (flushE),
        .pipe         (pipe),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        pipe.pcF = '0; pipe.instrF = '0; pipe.predict_takenF = 1'b0;
        pipe.rsD = 5'd1; pipe.rtD = 5'd2; pipe.writeregD = 5'd3;
        pipe.regwriteD = 1'b1; pipe.memtoregD = 1'b1; pipe.memwriteD = 1'b0; pipe.alusrcD = 1'b1;
        pipe.alucontrolD = 3'b010;
        pipe.srcaD = 32'h1111_1111; pipe.srcbD = 32'h2222_2222; pipe.signimmD = 32'h0000_0004;

        // reset state, before any clock edge
        #3;
        checkEq("rst_pcD", pipe.pcD, 32'h0);
        checkEq("rst_validD", 32'(pipe.validD), 32'h0);
        checkEq("rst_validE", 32'(pipe.validE), 32'h0);
        checkEq("rst_stall_cnt", stall_cnt, 32'h0);
        checkEq("rst_flush_cnt", flush_cnt, 32'h0);
        checkEq("rst_timeout", 32'(stall_timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic load
        pipe.pcF = 32'h100; pipe.instrF = 32'h8C01_0004; pipe.predict_takenF = 1'b1;
        tick(1);
        checkEq("load_pcD", pipe.pcD, 32'h100);
        checkEq("load_instrD", pipe.instrD, 32'h8C01_0004);
        checkEq("load_predD", 32'(pipe.predict_takenD), 32'h1);
        checkEq("load_validD", 32'(pipe.validD), 32'h1);
        checkEq("load_validE_c1", 32'(pipe.validE), 32'h0);
        pipe.pcF = 32'h104; pipe.predict_takenF = 1'b0;
        tick(1);
        checkEq("load_pcE", pipe.pcE, 32'h100);
        checkEq("load_validE", 32'(pipe.validE), 32'h1);
        checkEq("load_pcD2", pipe.pcD, 32'h104);
        checkEq("load_rsE", 32'(pipe.rsE), 32'd1);
        checkEq("load_writeregE", 32'(pipe.writeregE), 32'd3);
        checkEq("load_aluctlE", 32'(pipe.alucontrolE), 32'd2);
        checkEq("load_srcaE", pipe.srcaE, 32'h1111_1111);
        checkEq("load_signimmE", pipe.signimmE, 32'h4);
        checkEq("load_regwriteE", 32'(pipe.regwriteE), 32'h1);

        // stallD with flushE bubble
        pipe.pcF = 32'h108; stallD = 1'b1; flushE = 1'b1;
        tick(1);
        checkEq("stall_pcD_hold", pipe.pcD, 32'h104);
        checkEq("bubble_validE", 32'(pipe.validE), 32'h0);
        checkEq("bubble_regwriteE", 32'(pipe.regwriteE), 32'h0);
        checkEq("bubble_pcE", pipe.pcE, 32'h0);
        checkEq("bubble_rsE", 32'(pipe.rsE), 32'h0);
        checkEq("stall_cnt_1", stall_cnt, 32'd1);
        checkEq("flush_cnt_1", flush_cnt, 32'd1);
        stallD = 1'b0; flushE = 1'b0;
        tick(1);
        checkEq("resume_pcD", pipe.pcD, 32'h108);
        checkEq("resume_pcE", pipe.pcE, 32'h104);
        checkEq("resume_validE", 32'(pipe.validE), 32'h1);

        // flushD beats stallD; both flushes count once
        flushD = 1'b1; stallD = 1'b1; flushE = 1'b1; pipe.pcF = 32'h10C;
        tick(1);
        checkEq("flushD_instrD", pipe.instrD, 32'h0);
        checkEq("flushD_validD", 32'(pipe.validD), 32'h0);
        checkEq("flushD_pcD", pipe.pcD, 32'h0);
        checkEq("stall_cnt_2", stall_cnt, 32'd2);
        checkEq("flush_cnt_2", flush_cnt, 32'd2);
        flushD = 1'b0; stallD = 1'b0; flushE = 1'b0;
        tick(1);
        checkEq("after_flush_pcD", pipe.pcD, 32'h10C);
        checkEq("after_flush_validE", 32'(pipe.validE), 32'h0);

        // 15 stall cycles: just under the limit
        stallD = 1'b1; flushE = 1'b1;
        tick(15);
        stallD = 1'b0; flushE = 1'b0;
        tick(2);
        checkEq("wd15_timeout", 32'(stall_timeout), 32'h0);
        checkEq("stall_cnt_17", stall_cnt, 32'd17);
        checkEq("flush_cnt_17", flush_cnt, 32'd17);

        // 16 stall cycles: timeout appears on cycle 17 and sticks
        stallD = 1'b1; flushE = 1'b1;
        tick(16);
        checkEq("wd16_not_yet", 32'(stall_timeout), 32'h0);
        stallD = 1'b0; flushE = 1'b0;
        tick(1);
        checkEq("wd16_timeout", 32'(stall_timeout), 32'h1);
        tick(3);
        checkEq("wd16_sticky", 32'(stall_timeout), 32'h1);
        checkEq("stall_cnt_33", stall_cnt, 32'd33);

        // stall counter saturation, driven by stallF (no effect on F/D)
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        pipe.pcF = 32'h200; stallF = 1'b1;
        tick(1);
        checkEq("sat_step1", stall_cnt, 32'hFFFF_FFFF);
        checkEq("stallF_pcD", pipe.pcD, 32'h200);
        tick(2);
        checkEq("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        stallF = 1'b0;

        // asynchronous reset in the middle of a stall
        stallD = 1'b1; flushE = 1'b1;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("arst_pcD", pipe.pcD, 32'h0);
        checkEq("arst_validD", 32'(pipe.validD), 32'h0);
        checkEq("arst_instrD", pipe.instrD, 32'h0);
        checkEq("arst_stall_cnt", stall_cnt, 32'h0);
        checkEq("arst_flush_cnt", flush_cnt, 32'h0);
        checkEq("arst_timeout", 32'(stall_timeout), 32'h0);
        checkEq("arst_run", 32'(dut.uWatchdog.run), 32'h0);
        stallD = 1'b0; flushE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pipe.pcF = 32'h100; pipe.instrF = 32'h8C01_0004;
        tick(1);
        checkEq("post_rst_pcD", pipe.pcD, 32'h100);
        tick(1);
        checkEq("post_rst_pcE", pipe.pcE, 32'h100);
        checkEq("post_rst_validE", 32'(pipe.validE), 32'h1);

        // run restarts from zero after reset: 15 more stalls must not time out
        stallD = 1'b1; flushE = 1'b1;
        tick(15);
        stallD = 1'b0; flushE = 1'b0;
        tick(2);
        checkEq("post_rst_wd15", 32'(stall_timeout), 32'h0);
        checkEq("post_rst_stall_cnt", stall_cnt, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_regs.md
PIPE_CTRL_REGS -- requirements
Module: pipe_ctrl_regs

Interface
REQ-001 STALL_LIMIT, default 16, consecutive stallD cycles that set stall_timeout; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 stallF, stallD  in  1 each  hazard-unit stalls; high means hold.
REQ-005 flushD, flushE  in  1 each  clear the F/D register and the D/E register respectively.
REQ-006 pcF, instrF  in  32 each  fetch-stage PC and instruction.
REQ-007 predict_takenF  in  1  branch-predictor decision for the instruction in F.
REQ-008 pcD, instrD  out  32 each  F/D register contents.
REQ-009 predict_takenD, validD  out  1 each  F/D prediction bit; D slot holds a real instruction.
REQ-010 rsD, rtD, writeregD  in  5 each  decode register numbers.
REQ-011 regwriteD, memtoregD, memwriteD, alusrcD  in  1 each  decode control bits.
REQ-012 alucontrolD  in  3  decode ALU control.
REQ-013 srcaD, srcbD, signimmD  in  32 each  decode operands.
REQ-014 rsE, rtE, writeregE  out  5 each  D/E register numbers, returned to the hazard unit.
REQ-015 regwriteE, memtoregE, memwriteE, alusrcE, validE  out  1 each  D/E control bits and slot-valid flag.
REQ-016 alucontrolE  out  3; srcaE, srcbE, signimmE, pcE  out  32 each  D/E data.
REQ-017 stall_cnt, flush_cnt  out  32 each  performance counters.
REQ-018 stall_timeout  out  1  sticky watchdog flag.

Function
REQ-019 The F/D register shall update each cycle: if flushD, clear (pcD, instrD, predict_takenD, validD to 0); else if stallD, hold; else load pcF, instrF, predict_takenF and set validD to 1.
REQ-020 flushD shall take priority over stallD in the same cycle.
REQ-021 stallF shall have no effect on F/D state; it is used only for counting (REQ-024).
REQ-022 The D/E register shall update each cycle: if flushE, clear every E output including validE; else load all D fields and pcD, with validE equal to validD.
REQ-023 The D/E register has no hold; flushE is the only mechanism for inserting a bubble, and a stallD without flushE is forbidden.
REQ-024 stall_cnt shall increment by 1 in each cycle where stallF or stallD is high, and shall saturate at 0xFFFFFFFF.
REQ-025 flush_cnt shall increment by 1 in each cycle where flushD or flushE is high, counting once if both are high, and shall saturate at 0xFFFFFFFF.
REQ-026 The watchdog FSM shall have states IDLE and STALLING and an 8-bit run counter.
REQ-027 IDLE with stallD high: go to STALLING, run=1; STALLING with stallD high: run+1, saturating at 255; any state with stallD low: go to IDLE, run=0.
REQ-028 stall_timeout shall set in the cycle after run reaches STALL_LIMIT, and shall remain set until reset.
REQ-029 All outputs shall be registered, with single-cycle latency from input to output.

Reset
REQ-030 While rst_n is low, every output, both counters, run, and stall_timeout shall be 0, and the FSM shall be in IDLE, independent of clk.
REQ-031 Reset assertion mid-stall shall abort the run; after release, counting shall restart from 0.

Structure
REQ-032 A shared pipeline package shall hold the register-number width (5), the data width (32), the alucontrol width (3), and the watchdog state encoding.
REQ-033 One sub-module, pipe_watchdog, shall contain the FSM, the run counter, and stall_timeout; the registers and counters shall stay at top level.

Verification
REQ-034 Load pcF=0x100, instrF=0x8C010004 with no stall or flush -> pcD=0x100 after 1 cycle; pcE=0x100, validE=1 after 2 cycles.
REQ-035 stallD=1 and flushE=1 for 1 cycle with pcD=0x104 -> pcD remains 0x104, validE=0, regwriteE=0, stall_cnt +1, flush_cnt +1.
REQ-036 flushD=1 and stallD=1 in the same cycle -> instrD=0, validD=0.
REQ-037 stallD high for 16 cycles with STALL_LIMIT=16 -> stall_timeout=1 on cycle 17 and stays 1 after stallD drops; with 15 cycles, stall_timeout stays 0.
REQ-038 Preload stall_cnt to 0xFFFFFFFE by forcing, then stall for 3 cycles -> stall_cnt=0xFFFFFFFF.
REQ-039 Drop rst_n asynchronously between clock edges during a stall -> all outputs 0 immediately; after release, first load behaves as in REQ-034.
